// File: rtl/sap3_pkg.sv
// Shared definitions for the sap3 serial array blocks: serializer FSM
// encodings and the default inter-frame gap, kept next to the deserializer
// definitions so both ends agree on framing.
package sap3_pkg;

    // Serializer FSM encoding (legacy-compatible constants, not an enum type).
    localparam int         SER_STATE_W = 2;
    localparam logic [1:0] SER_IDLE    = 2'd0;
    localparam logic [1:0] SER_SHIFT   = 2'd1;
    localparam logic [1:0] SER_GAP     = 2'd2;

    // Idle cycles inserted after every frame unless overridden (1..15).
    localparam int SER_GAP_DEFAULT = 2;

endpackage

// File: rtl/array_serializer.sv
// Array serializer: captures a WIDTH*DEPTH flattened array and streams it
// one bit per cycle, word 0 first and MSB first within each word, followed
// by GAP quiet cycles and a one-cycle done pulse.
//
// Request semantics: load (or a held periodic) is a level request sampled
// only in IDLE; there is no acknowledge. A request is taken on any IDLE edge
// except the done cycle, which still belongs to the finished frame, so a
// request seen there is dropped and never queued. Requests during SHIFT or
// GAP are likewise dropped. periodic re-arms straight from GAP to SHIFT.
module array_serializer
    import sap3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int GAP   = SER_GAP_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     periodic,
    input  logic [WIDTH*DEPTH-1:0]   data_in,
    output logic                     serial_out,
    output logic                     start,
    output logic                     busy,
    output logic                     done
);

    localparam int TOTAL = WIDTH * DEPTH;
    localparam int CNT_W = $clog2(TOTAL);

    logic [SER_STATE_W-1:0] state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [3:0]             gap_cnt;
    logic [TOTAL-1:0]       shreg;
    logic [TOTAL-1:0]       frame_ordered;
    logic                   req;
    logic                   last_bit;
    logic                   gap_end;

    // Reverse the word order so a plain MSB-first shift of the whole vector
    // emits word 0 first, each word MSB first.
    always_comb begin
        frame_ordered = '0;
        for (int k = 0; k < DEPTH; k++) begin
            frame_ordered[(DEPTH-1-k)*WIDTH +: WIDTH] = data_in[k*WIDTH +: WIDTH];
        end
    end

    assign req      = (load | periodic) & ~done;
    assign last_bit = (bit_cnt == CNT_W'(TOTAL - 1));
    assign gap_end  = (gap_cnt == 4'(GAP - 1));

    // Outputs decode from registered state so reset clears them at once.
    assign busy       = (state == SER_SHIFT) || (state == SER_GAP);
    assign serial_out = (state == SER_SHIFT) & shreg[TOTAL-1];
    assign start      = (state == SER_SHIFT) && (bit_cnt == '0);

    // Frame FSM with shift register, bit counter, gap counter and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SER_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SER_IDLE: begin
                    if (req) begin
                        shreg   <= frame_ordered;
                        bit_cnt <= '0;
                        state   <= SER_SHIFT;
                    end
                end
                SER_SHIFT: begin
                    shreg <= {shreg[TOTAL-2:0], 1'b0};
                    if (last_bit) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= SER_GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                SER_GAP: begin
                    if (gap_end) begin
                        done    <= 1'b1;
                        gap_cnt <= '0;
                        if (periodic) begin
                            shreg   <= frame_ordered;
                            bit_cnt <= '0;
                            state   <= SER_SHIFT;
                        end else begin
                            state <= SER_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_serializer.sv
// Directed bench for array_serializer: a default instance (8x12, gap 2) and
// a small instance (4x3, gap 1). Inputs are driven and outputs sampled on the
// falling edge; expected streams are rebuilt word by word from the data.
module tb_array_serializer;

    logic        clk;
    logic        rst;

    logic        a_load, a_periodic;
    logic [95:0] a_data;
    logic        a_serial, a_start, a_busy, a_done;

    logic        b_load, b_periodic;
    logic [11:0] b_data;
    logic        b_serial, b_start, b_busy, b_done;

    int checks;
    int failures;

    array_serializer dut_a (
        .clk        (clk),
        .rst        (rst),
        .load       (a_load),
        .periodic   (a_periodic),
        .data_in    (a_data),
        .serial_out (a_serial),
        .start      (a_start),
        .busy       (a_busy),
        .done       (a_done)
    );

    array_serializer #(.WIDTH(4), .DEPTH(3), .GAP(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .load       (b_load),
        .periodic   (b_periodic),
        .data_in    (b_data),
        .serial_out (b_serial),
        .start      (b_start),
        .busy       (b_busy),
        .done       (b_done)
    );

    // clock and time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout no summary reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {serial_out, start, busy, done} of the selected instance
    function automatic logic [3:0] outs(input int sel);
        if (sel == 0) return {a_serial, a_start, a_busy, a_done};
        return {b_serial, b_start, b_busy, b_done};
    endfunction

    task automatic drive(input int sel, input logic ld, input logic [95:0] d, input logic per);
        if (sel == 0) begin
            a_load = ld; a_data = d; a_periodic = per;
        end else begin
            b_load = ld; b_data = d[11:0]; b_periodic = per;
        end
    endtask

    task automatic set_load(input int sel, input logic ld);
        if (sel == 0) a_load = ld;
        else b_load = ld;
    endtask

    // words k = base + k*step, 8 bits each, 12 words
    function automatic logic [95:0] mk_data(input logic [7:0] base, input logic [7:0] step);
        logic [95:0] d;
        logic [7:0]  w;
        d = '0;
        w = base;
        for (int k = 0; k < 12; k++) begin
            d[k*8 +: 8] = w;
            w = w + step;
        end
        return d;
    endfunction

    // s[n] = n-th transmitted bit: word 0 first, MSB first
    function automatic logic [95:0] expect_stream(input logic [95:0] d, input int width, input int depth);
        logic [95:0] s;
        int n;
        s = '0;
        n = 0;
        for (int k = 0; k < depth; k++) begin
            for (int b = width - 1; b >= 0; b--) begin
                s[n] = d[k*width + b];
                n++;
            end
        end
        return s;
    endfunction

    // Starts at the falling edge of the start cycle; ends at the falling edge
    // of the done cycle. One stimulus change is applied at bit poke_at.
    task automatic observe_frame(input int sel, input int nbits, input int gap, input string tag,
                                 input int poke_at, input logic poke_load,
                                 input logic [95:0] poke_data, input logic poke_periodic,
                                 output logic [95:0] got);
        logic [3:0] o;
        int start_err, busy_err, done_err, gap_err;
        start_err = 0; busy_err = 0; done_err = 0; gap_err = 0;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) @(negedge clk);
            o = outs(sel);
            got[i] = o[3];
            if (i == 0) check({tag, "_start_first"}, 96'(o[2]), 96'd1);
            else if (o[2] !== 1'b0) start_err++;
            if (o[1] !== 1'b1) busy_err++;
            if (i > 0 && o[0] !== 1'b0) done_err++;
            if (i == poke_at) drive(sel, poke_load, poke_data, poke_periodic);
            else if (i == poke_at + 1) set_load(sel, 1'b0);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            o = outs(sel);
            if (o !== 4'b0010) gap_err++;
        end
        @(negedge clk);
        o = outs(sel);
        check({tag, "_done_pulse"}, 96'(o[0]), 96'd1);
        check({tag, "_start_only_first"}, 96'(start_err), 96'd0);
        check({tag, "_busy_in_frame"}, 96'(busy_err), 96'd0);
        check({tag, "_no_early_done"}, 96'(done_err), 96'd0);
        check({tag, "_gap_quiet"}, 96'(gap_err), 96'd0);
    endtask

    // one directed sequence
    initial begin
        logic [95:0] got;
        logic [95:0] d1, d2, d3;
        logic [11:0] v12;
        logic [7:0]  v8;
        int cnt_done, cnt_busy;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        d1 = mk_data(8'h01, 8'h01);
        d2 = mk_data(8'hA0, 8'h03);
        d3 = mk_data(8'h5A, 8'h11);

        // reset state
        @(negedge clk);
        check("reset_outs_a", 96'(outs(0)), 96'd0);
        check("reset_outs_b", 96'(outs(1)), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset_a", 96'(outs(0)), 96'd0);
        check("idle_after_reset_b", 96'(outs(1)), 96'd0);

        // T1: single load of words 0x01..0x0C, extra load mid-frame ignored
        drive(0, 1'b1, d1, 1'b0);
        check("t1_start_not_early", 96'(a_start), 96'd0);
        @(negedge clk);
        set_load(0, 1'b0);
        observe_frame(0, 96, 2, "t1", 10, 1'b1, d1, 1'b0, got);
        check("t1_stream", got, expect_stream(d1, 8, 12));
        v8 = '0;
        for (int i = 0; i < 8; i++) v8 = {v8[6:0], got[i]};
        check("t1_word0", 96'(v8), 96'h01);
        v8 = '0;
        for (int i = 88; i < 96; i++) v8 = {v8[6:0], got[i]};
        check("t1_word11", 96'(v8), 96'h0C);
        check("t1_idle_after_done", 96'(outs(0)), 96'b0001);
        cnt_done = 0;
        cnt_busy = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (a_done) cnt_done++;
            if (a_busy) cnt_busy++;
        end
        check("t1_no_queued_frame", 96'(cnt_busy), 96'd0);
        check("t1_single_done", 96'(cnt_done), 96'd0);

        // T2: periodic back-to-back, data changed mid-frame
        drive(0, 1'b0, d2, 1'b1);
        @(negedge clk);
        observe_frame(0, 96, 2, "t2f1", 40, 1'b0, d3, 1'b1, got);
        check("t2f1_stream", got, expect_stream(d2, 8, 12));
        check("t2_back_to_back", 96'(a_start), 96'd1);
        observe_frame(0, 96, 2, "t2f2", 50, 1'b0, d1, 1'b0, got);
        check("t2f2_stream", got, expect_stream(d3, 8, 12));
        check("t2_stop_idle", 96'({a_start, a_busy}), 96'd0);

        // T3: asynchronous reset at bit 40
        @(negedge clk);
        drive(0, 1'b1, d1, 1'b0);
        @(negedge clk);
        set_load(0, 1'b0);
        repeat (40) @(negedge clk);
        check("t3_busy_before_rst", 96'(a_busy), 96'd1);
        rst = 1'b1;
        #1;
        check("t3_async_clear_a", 96'(outs(0)), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        cnt_busy = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (a_done) cnt_done++;
            if (a_busy) cnt_busy++;
        end
        check("t3_no_done", 96'(cnt_done), 96'd0);
        check("t3_stays_idle", 96'(cnt_busy), 96'd0);
        drive(0, 1'b1, d2, 1'b0);
        @(negedge clk);
        set_load(0, 1'b0);
        observe_frame(0, 96, 2, "t3", -1, 1'b0, d2, 1'b0, got);
        check("t3_clean_stream", got, expect_stream(d2, 8, 12));

        // T4: load during the done cycle is dropped, one cycle later is taken
        @(negedge clk);
        drive(0, 1'b1, d3, 1'b0);
        @(negedge clk);
        set_load(0, 1'b0);
        observe_frame(0, 96, 2, "t4a", -1, 1'b0, d3, 1'b0, got);
        set_load(0, 1'b1);
        @(negedge clk);
        check("t4_done_cycle_load_ignored", 96'({a_start, a_busy}), 96'd0);
        @(negedge clk);
        check("t4_load_after_done", 96'(a_start), 96'd1);
        observe_frame(0, 96, 2, "t4b", -1, 1'b0, d3, 1'b0, got);
        check("t4b_stream", got, expect_stream(d3, 8, 12));

        // T5: 4x3 instance, gap 1, words 0xA, 0x5, 0xF
        drive(1, 1'b1, 96'hF5A, 1'b0);
        @(negedge clk);
        set_load(1, 1'b0);
        observe_frame(1, 12, 1, "t5", -1, 1'b0, 96'hF5A, 1'b0, got);
        v12 = '0;
        for (int i = 0; i < 12; i++) v12 = {v12[10:0], got[i]};
        check("t5_stream_a5f", 96'(v12), 96'hA5F);
        check("t5_stream_model", got, expect_stream(96'hF5A, 4, 3));
        @(negedge clk);
        check("t5_idle_after", 96'(outs(1)), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
